// File: rtl/dcpu16_marb.sv
// dcpu16_marb: arbitrates the CPU G-bus and F-bus onto one memory port.
// Ports: clk/rst; g_*/f_* slave ports from the CPU; m_* master port to memory.
module dcpu16_marb #(
   parameter int RR = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] g_adr,
   input  logic        g_stb,
   input  logic        g_wre,
   input  logic [15:0] g_dto,
   output logic [15:0] g_dti,
   output logic        g_ack,
   input  logic [15:0] f_adr,
   input  logic        f_stb,
   input  logic        f_wre,
   input  logic [15:0] f_dto,
   output logic [15:0] f_dti,
   output logic        f_ack,
   output logic [15:0] m_adr,
   output logic        m_stb,
   output logic        m_wre,
   output logic [15:0] m_dto,
   input  logic [15:0] m_dti,
   input  logic        m_ack
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GNT_F,
      S_GNT_G,
      S_DONE_F,
      S_DONE_G
   } state_t;

   state_t r_state;
   logic   r_last_f;
   logic   w_pick_f;

   // F wins from IDLE unless G also asks and round-robin says G's turn
   assign w_pick_f = f_stb &&
                     (!g_stb || (RR == 0) || !r_last_f);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_last_f <= 1'b0;
         m_adr    <= '0;
         m_dto    <= '0;
         m_stb    <= 1'b0;
         m_wre    <= 1'b0;
         f_ack    <= 1'b0;
         g_ack    <= 1'b0;
         f_dti    <= '0;
         g_dti    <= '0;
      end else begin
         f_ack <= 1'b0;
         g_ack <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_pick_f) begin
                  r_state <= S_GNT_F;
                  m_adr   <= f_adr;
                  m_wre   <= f_wre;
                  m_dto   <= f_dto;
                  m_stb   <= 1'b1;
               end else if (g_stb) begin
                  r_state <= S_GNT_G;
                  m_adr   <= g_adr;
                  m_wre   <= g_wre;
                  m_dto   <= g_dto;
                  m_stb   <= 1'b1;
               end
            end
            S_GNT_F: begin
               if (m_ack) begin
                  m_stb    <= 1'b0;
                  f_dti    <= m_dti;
                  f_ack    <= 1'b1;
                  r_last_f <= 1'b1;
                  r_state  <= S_DONE_F;
               end
            end
            S_GNT_G: begin
               if (m_ack) begin
                  m_stb    <= 1'b0;
                  g_dti    <= m_dti;
                  g_ack    <= 1'b1;
                  r_last_f <= 1'b0;
                  r_state  <= S_DONE_G;
               end
            end
            // the just-acked port waits for IDLE; only the other may chain
            S_DONE_F: begin
               if (g_stb) begin
                  r_state <= S_GNT_G;
                  m_adr   <= g_adr;
                  m_wre   <= g_wre;
                  m_dto   <= g_dto;
                  m_stb   <= 1'b1;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_DONE_G: begin
               if (f_stb) begin
                  r_state <= S_GNT_F;
                  m_adr   <= f_adr;
                  m_wre   <= f_wre;
                  m_dto   <= f_dto;
                  m_stb   <= 1'b1;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dcpu16_marb.sv
// tb_dcpu16_marb: checks a fixed-priority and a round-robin instance
// against a transaction-level model, plus directed literal checks.
module tb_dcpu16_marb;

   localparam int PF   = 0;
   localparam int PG   = 1;
   localparam int NONE = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic [15:0] g_adr = '0, g_dto = '0, f_adr = '0, f_dto = '0;
   logic        g_stb = 1'b0, g_wre = 1'b0, f_stb = 1'b0, f_wre = 1'b0;

   logic [15:0] g_dti [2];
   logic [15:0] f_dti [2];
   logic [15:0] m_adr [2];
   logic [15:0] m_dto [2];
   logic [15:0] m_dti [2];
   logic        g_ack [2];
   logic        f_ack [2];
   logic        m_stb [2];
   logic        m_wre [2];
   logic        m_ack [2];

   dcpu16_marb #(.RR(0)) u_fix (
      .clk(clk), .rst(rst),
      .g_adr(g_adr), .g_stb(g_stb), .g_wre(g_wre), .g_dto(g_dto),
      .g_dti(g_dti[0]), .g_ack(g_ack[0]),
      .f_adr(f_adr), .f_stb(f_stb), .f_wre(f_wre), .f_dto(f_dto),
      .f_dti(f_dti[0]), .f_ack(f_ack[0]),
      .m_adr(m_adr[0]), .m_stb(m_stb[0]), .m_wre(m_wre[0]),
      .m_dto(m_dto[0]), .m_dti(m_dti[0]), .m_ack(m_ack[0])
   );

   dcpu16_marb #(.RR(1)) u_rr (
      .clk(clk), .rst(rst),
      .g_adr(g_adr), .g_stb(g_stb), .g_wre(g_wre), .g_dto(g_dto),
      .g_dti(g_dti[1]), .g_ack(g_ack[1]),
      .f_adr(f_adr), .f_stb(f_stb), .f_wre(f_wre), .f_dto(f_dto),
      .f_dti(f_dti[1]), .f_ack(f_ack[1]),
      .m_adr(m_adr[1]), .m_stb(m_stb[1]), .m_wre(m_wre[1]),
      .m_dto(m_dto[1]), .m_dti(m_dti[1]), .m_ack(m_ack[1])
   );

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   logic [15:0] mem [0:65535];
   int          mem_wait = 0;
   int          wcnt [2];

   // model: which port owns memory, which port is acked this cycle
   int          cur  [2];
   int          ackp [2];
   int          last [2];
   logic [15:0] e_adr [2];
   logic [15:0] e_dto [2];
   logic        e_wre [2];
   logic [15:0] e_dti [2][2];
   bit          armed = 1'b0;
   int          pa, pick;
   bit          sf, sg;

   task automatic chk(input string nm, input int inst,
                      input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %h want %h at %0t",
                  nm, inst, act, exp, $time);
      end
   endtask

   // one cycle: memory response, compare, model advance, next edge
   task automatic tick();
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         if (m_stb[i] !== 1'b1) begin
            wcnt[i]  = 0;
            m_ack[i] = 1'b0;
            m_dti[i] = 16'hCCCC;
         end else begin
            if (wcnt[i] == mem_wait) begin
               m_ack[i] = 1'b1;
               m_dti[i] = mem[m_adr[i]];
            end else begin
               m_ack[i] = 1'b0;
               m_dti[i] = 16'hCCCC;
            end
            wcnt[i]++;
         end
      end
      if (armed) begin
         for (int i = 0; i < 2; i++) begin
            chk("m_stb", i, m_stb[i], 16'(cur[i] != NONE));
            chk("m_adr", i, m_adr[i], e_adr[i]);
            chk("m_wre", i, m_wre[i], e_wre[i]);
            chk("m_dto", i, m_dto[i], e_dto[i]);
            chk("f_ack", i, f_ack[i], 16'(ackp[i] == PF));
            chk("g_ack", i, g_ack[i], 16'(ackp[i] == PG));
            chk("f_dti", i, f_dti[i], e_dti[i][PF]);
            chk("g_dti", i, g_dti[i], e_dti[i][PG]);
            chk("ack_excl", i, f_ack[i] & g_ack[i], 16'h0);
         end
      end
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            cur[i]       = NONE;
            ackp[i]      = NONE;
            last[i]      = PG;
            e_adr[i]     = '0;
            e_dto[i]     = '0;
            e_wre[i]     = 1'b0;
            e_dti[i][PF] = '0;
            e_dti[i][PG] = '0;
         end else begin
            pa      = ackp[i];
            ackp[i] = NONE;
            if (cur[i] != NONE) begin
               if (m_ack[i]) begin
                  e_dti[i][cur[i]] = m_dti[i];
                  ackp[i] = cur[i];
                  last[i] = cur[i];
                  cur[i]  = NONE;
               end
            end else begin
               sf = f_stb && (pa != PF);
               sg = g_stb && (pa != PG);
               if (sf && sg)
                  pick = (i == 1 && last[i] == PF) ? PG : PF;
               else if (sf)
                  pick = PF;
               else if (sg)
                  pick = PG;
               else
                  pick = NONE;
               if (pick == PF) begin
                  cur[i] = PF;
                  e_adr[i] = f_adr;
                  e_wre[i] = f_wre;
                  e_dto[i] = f_dto;
               end else if (pick == PG) begin
                  cur[i] = PG;
                  e_adr[i] = g_adr;
                  e_wre[i] = g_wre;
                  e_dto[i] = g_dto;
               end
            end
         end
      end
      armed = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic bit ackv(input int inst, input bit pf);
      return pf ? f_ack[inst] : g_ack[inst];
   endfunction

   task automatic wait_ack(input int inst, input bit pf);
      bit got = 1'b0;
      for (int n = 0; n < 40 && !got; n++) begin
         if (ackv(inst, pf)) got = 1'b1;
         else tick();
      end
      n_chk++;
      if (!got) begin
         n_fail++;
         $display("FAIL ack_timeout[%0d]: got no ack want ack", inst);
      end
   endtask

   int t1, t2;
   int seq [2][4];
   int nseq [2];

   initial begin
      for (int a = 0; a < 65536; a++) mem[a] = 16'(a) ^ 16'h5A5A;
      for (int i = 0; i < 2; i++) begin
         m_ack[i] = 1'b0;
         m_dti[i] = 16'hCCCC;
         wcnt[i]  = 0;
      end
      tick(); tick(); tick();
      rst = 1'b0;
      tick();
      chk("rst_m_stb", 0, m_stb[0], 16'h0);
      chk("rst_g_dti", 0, g_dti[0], 16'h0);
      chk("rst_m_adr", 1, m_adr[1], 16'h0);

      // G read, k=0
      mem[16'h0010] = 16'h1234;
      g_adr = 16'h0010; g_stb = 1'b1;
      tick();
      chk("gr_m_stb", 0, m_stb[0], 16'h1);
      chk("gr_m_adr", 0, m_adr[0], 16'h0010);
      chk("gr_m_wre", 0, m_wre[0], 16'h0);
      tick();
      chk("gr_g_ack", 0, g_ack[0], 16'h1);
      chk("gr_g_dti", 0, g_dti[0], 16'h1234);
      chk("gr_f_ack", 0, f_ack[0], 16'h0);
      g_stb = 1'b0;
      tick(); tick();

      // F write, k=2
      mem_wait = 2;
      f_adr = 16'hFFFF; f_wre = 1'b1; f_dto = 16'hBEEF; f_stb = 1'b1;
      for (int j = 0; j < 3; j++) begin
         tick();
         chk("fw_m_stb", 0, m_stb[0], 16'h1);
         chk("fw_m_dto", 0, m_dto[0], 16'hBEEF);
         chk("fw_m_adr", 0, m_adr[0], 16'hFFFF);
      end
      tick();
      chk("fw_f_ack", 0, f_ack[0], 16'h1);
      f_stb = 1'b0; f_wre = 1'b0;
      tick();
      chk("fw_f_ack_once", 0, f_ack[0], 16'h0);
      tick(); tick();

      // simultaneous; RR instance last served F so it picks G
      mem_wait = 0;
      mem[16'h0001] = 16'hAAAA;
      mem[16'h0002] = 16'h5555;
      f_adr = 16'h0001; g_adr = 16'h0002;
      f_stb = 1'b1; g_stb = 1'b1;
      tick(); tick();
      chk("sim_f_ack", 0, f_ack[0], 16'h1);
      chk("sim_f_dti", 0, f_dti[0], 16'hAAAA);
      chk("sim_done_m_stb", 0, m_stb[0], 16'h0);
      chk("sim_rr_g_ack", 1, g_ack[1], 16'h1);
      chk("sim_rr_g_dti", 1, g_dti[1], 16'h5555);
      f_stb = 1'b0;
      tick();
      chk("sim_g_m_stb", 0, m_stb[0], 16'h1);
      chk("sim_g_m_adr", 0, m_adr[0], 16'h0002);
      tick();
      chk("sim_g_ack", 0, g_ack[0], 16'h1);
      chk("sim_g_dti", 0, g_dti[0], 16'h5555);
      g_stb = 1'b0;
      for (int j = 0; j < 5; j++) tick();

      // both held for 4 transactions after reset, k=1
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mem_wait = 1;
      f_adr = 16'h0020; g_adr = 16'h0021;
      f_stb = 1'b1; g_stb = 1'b1;
      nseq[0] = 0; nseq[1] = 0;
      for (int n = 0; n < 60 && nseq[1] < 4; n++) begin
         tick();
         for (int i = 0; i < 2; i++) begin
            if (nseq[i] < 4 && f_ack[i]) begin
               seq[i][nseq[i]] = PF; nseq[i]++;
            end else if (nseq[i] < 4 && g_ack[i]) begin
               seq[i][nseq[i]] = PG; nseq[i]++;
            end
         end
      end
      f_stb = 1'b0; g_stb = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chk("rr_count", i, 16'(nseq[i]), 16'd4);
         for (int j = 0; j < 4; j++)
            chk("rr_order", i, 16'(seq[i][j]), 16'(j % 2));
      end
      tick(); tick();

      // back-to-back on G
      mem_wait = 0;
      mem[16'h0100] = 16'h1111;
      mem[16'h0101] = 16'h2222;
      g_adr = 16'h0100; g_stb = 1'b1;
      wait_ack(0, 1'b0);
      t1 = cyc;
      chk("b2b_dti0", 0, g_dti[0], 16'h1111);
      g_adr = 16'h0101;
      tick();
      chk("b2b_gap", 0, m_stb[0], 16'h0);
      tick();
      chk("b2b_m_adr", 0, m_adr[0], 16'h0101);
      wait_ack(0, 1'b0);
      t2 = cyc;
      chk("b2b_spacing", 0, 16'(t2 - t1), 16'd3);
      chk("b2b_dti1", 0, g_dti[0], 16'h2222);
      g_stb = 1'b0;
      tick();
      chk("b2b_no_dbl", 0, g_ack[0], 16'h0);
      tick(); tick();

      // reset while memory stalls
      mem_wait = 5;
      mem[16'h0030] = 16'h3333;
      f_adr = 16'h0030; f_wre = 1'b0; f_stb = 1'b1;
      tick();
      chk("rm_m_stb", 0, m_stb[0], 16'h1);
      rst = 1'b1;
      tick();
      chk("rm_m_stb_clr", 0, m_stb[0], 16'h0);
      chk("rm_f_ack", 0, f_ack[0], 16'h0);
      chk("rm_f_dti", 0, f_dti[0], 16'h0);
      rst = 1'b0;
      mem_wait = 0;
      tick();
      chk("rm_reissue", 0, m_stb[0], 16'h1);
      chk("rm_m_adr", 0, m_adr[0], 16'h0030);
      tick();
      chk("rm_f_ack2", 0, f_ack[0], 16'h1);
      chk("rm_f_dti2", 0, f_dti[0], 16'h3333);
      f_stb = 1'b0;
      tick(); tick(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end want end");
      $fatal(1, "watchdog");
   end

endmodule
